// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the output packer.
package conv_pkg;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_LANES = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } pk_state_e;

endpackage

// File: rtl/output_packer.sv
// Packs W-bit FIFO entries into LANES-wide words with keep/last and flush support.
// Optional OUTPUT_PACKER_STATS_EN adds a 32-bit accepted-word counter output.
module output_packer
    import conv_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int LANES = DEFAULT_LANES
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [W-1:0]       fifo_rd_data,
    input  logic               fifo_empty,
    input  logic               fifo_wr_en,
    output logic               fifo_rd_en,
    input  logic               flush,
    output logic [W*LANES-1:0] m_data,
    output logic [LANES-1:0]   m_keep,
    output logic               m_last,
    output logic               m_valid,
    input  logic               m_ready
`ifdef OUTPUT_PACKER_STATS_EN
    ,
    output logic [31:0]        word_count
`endif
);

    localparam int CW = $clog2(LANES + 1);

    pk_state_e        state_q;
    logic [CW-1:0]    fill_cnt_q;
    logic             pending_q;
    logic             flush_req_q;
    logic             flush_req_d;
    logic [W-1:0]     lanes_q [LANES];
    logic [LANES-1:0] m_keep_q;
    logic             m_last_q;
    logic [LANES-1:0] keep_partial;
    logic [CW:0]      inflight;
    logic             handshake;
    logic             word_full;
    logic             flush_partial;
    logic             flush_idle;

    // Bytes already captured plus the one still arriving from the FIFO.
    assign inflight = {1'b0, fill_cnt_q} + {{CW{1'b0}}, pending_q};

    // The FIFO drops a read that coincides with a write, so never read then.
    assign fifo_rd_en = rstn && (state_q == ST_FILL) && !fifo_empty && !fifo_wr_en
                        && (inflight < (CW+1)'(LANES));

    assign handshake     = (state_q == ST_OUT) && m_ready;
    assign word_full     = (state_q == ST_FILL) && pending_q && (fill_cnt_q == CW'(LANES - 1));
    assign flush_partial = (state_q == ST_FILL) && flush_req_q && !pending_q && !fifo_rd_en
                           && (fill_cnt_q != '0);
    assign flush_idle    = (state_q == ST_FILL) && flush_req_q && !pending_q && (fill_cnt_q == '0);

    // A fresh pulse in the consuming cycle starts a new request.
    always_comb begin
        flush_req_d = flush_req_q | flush;
        if (flush_partial || flush_idle || (word_full && flush_req_q && fifo_empty)) begin
            flush_req_d = flush;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign m_data[gi*W +: W] = lanes_q[gi];
        assign keep_partial[gi]  = (CW'(gi) < fill_cnt_q);
    end

    assign m_valid = (state_q == ST_OUT);
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= '0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            pending_q   <= fifo_rd_en;
            flush_req_q <= flush_req_d;
            case (state_q)
                ST_FILL: begin
                    if (pending_q) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (fill_cnt_q == CW'(i)) begin
                                lanes_q[i] <= fifo_rd_data;
                            end
                        end
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                    end
                    if (word_full) begin
                        state_q  <= ST_OUT;
                        m_keep_q <= '1;
                        m_last_q <= flush_req_q && fifo_empty;
                    end else if (flush_partial) begin
                        state_q  <= ST_OUT;
                        m_keep_q <= keep_partial;
                        m_last_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (handshake) begin
                        state_q    <= ST_FILL;
                        fill_cnt_q <= '0;
                        m_keep_q   <= '0;
                        m_last_q   <= 1'b0;
                        for (int i = 0; i < LANES; i++) begin
                            lanes_q[i] <= '0;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

`ifdef OUTPUT_PACKER_STATS_EN
    logic [31:0] word_count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_count_q <= '0;
        end else if (handshake) begin
            word_count_q <= word_count_q + 32'd1;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_output_packer.sv
// Randomized bench for output_packer: FIFO model, byte-stream word model, scoreboard.
module tb_output_packer;
    import conv_pkg::*;

    localparam int W     = DEFAULT_W;
    localparam int LANES = DEFAULT_LANES;
    localparam int DW    = W * LANES;

    logic             clk = 1'b0;
    logic             rstn;
    logic [W-1:0]     fifo_rd_data;
    logic             fifo_empty;
    logic             fifo_wr_en;
    logic             fifo_rd_en;
    logic             flush;
    logic [DW-1:0]    m_data;
    logic [LANES-1:0] m_keep;
    logic             m_last;
    logic             m_valid;
    logic             m_ready;
`ifdef OUTPUT_PACKER_STATS_EN
    logic [31:0]      word_count;
`endif

    always #5 clk = ~clk;

    output_packer #(.W(W), .LANES(LANES)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .m_data       (m_data),
        .m_keep       (m_keep),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
`ifdef OUTPUT_PACKER_STATS_EN
        ,
        .word_count   (word_count)
`endif
    );

    typedef struct {
        logic [DW-1:0]    data;
        logic [LANES-1:0] keep;
        logic             last;
    } word_t;

    word_t       exp_q[$];
    logic [W-1:0] model_bytes[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] wr_q[$];
    logic [W-1:0] rd_data_next;
    int          n_checks = 0;
    int          n_errors = 0;
    int          words_seen = 0;
    int unsigned hs_count = 0;
    int          wr_pct = 100;
    int          ready_pct = 100;
    logic        flush_now = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word model: bytes in write order, closed every LANES bytes or by a flush.
    task automatic emit_word(input logic last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < model_bytes.size(); i++) begin
            w.data[i*W +: W] = model_bytes[i];
            w.keep[i]        = 1'b1;
        end
        w.last = last;
        exp_q.push_back(w);
        model_bytes.delete();
    endtask

    task automatic model_push(input logic [W-1:0] b);
        model_bytes.push_back(b);
        if (model_bytes.size() == LANES) emit_word(1'b0);
    endtask

    task automatic queue_byte(input logic [W-1:0] b);
        wr_q.push_back(b);
        model_push(b);
    endtask

    task automatic queue_random(input int n);
        for (int i = 0; i < n; i++) queue_byte(W'($urandom));
    endtask

    // Observes the values the DUT will see at the next rising edge.
    task automatic sample();
        if (fifo_rd_en) begin
            check("rd_while_wr", fifo_wr_en, 0);
            check("rd_while_empty", fifo_empty, 0);
        end
        if (fifo_rd_en && !fifo_wr_en && fq.size() > 0) rd_data_next = fq.pop_front();
        else rd_data_next = W'($urandom);
        if (fifo_wr_en) fq.push_back(wr_q.pop_front());
        if (m_valid) begin
            check("rd_in_out", fifo_rd_en, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_word", m_valid, 0);
            end else begin
                check("m_data", m_data, exp_q[0].data);
                check("m_keep", m_keep, exp_q[0].keep);
                check("m_last", m_last, exp_q[0].last);
                if (m_ready) begin
                    $display("word %0d: data=%h keep=%b last=%b", words_seen, m_data, m_keep, m_last);
                    words_seen++;
                    hs_count++;
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        fifo_rd_data = rd_data_next;
        fifo_empty   = (fq.size() == 0);
        fifo_wr_en   = (wr_q.size() > 0) && (int'($urandom_range(99)) < wr_pct);
        m_ready      = (int'($urandom_range(99)) < ready_pct);
        flush        = flush_now;
        flush_now    = 1'b0;
        @(negedge clk);
        sample();
    endtask

    task automatic wait_fifo_idle();
        int n = 0;
        while ((wr_q.size() > 0 || fq.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        check("fifo_idle_timeout", n < 2000, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((wr_q.size() > 0 || fq.size() > 0 || exp_q.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        check("drain_timeout", n < 2000, 1);
        repeat (2) step();
    endtask

    task automatic quiesce_flush();
        wait_fifo_idle();
        repeat (3) step();
        flush_now = 1'b1;
        step();
        if (model_bytes.size() > 0) emit_word(1'b1);
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; fifo_rd_data = '0; fifo_empty = 1'b0; fifo_wr_en = 1'b0;
        flush = 1'b0; m_ready = 1'b0; rd_data_next = '0;
        #2;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_keep", m_keep, 0);
        check("rst_last", m_last, 0);
`ifdef OUTPUT_PACKER_STATS_EN
        check("rst_word_count", word_count, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        fifo_empty = 1'b1;
        rstn = 1'b1;
        @(negedge clk);

        // Four bytes, consumer always ready.
        wr_pct = 100; ready_pct = 100;
        queue_byte(8'h11); queue_byte(8'h22); queue_byte(8'h33); queue_byte(8'h44);
        wait_drain();

        // Long write burst: reads must stay off while the write strobe is high.
        queue_random(8);
        wait_drain();

        // Two bytes then a flush give a partial word.
        queue_byte(8'hAA); queue_byte(8'hBB);
        quiesce_flush();

        // Consumer stalls for 10 cycles on a held word.
        ready_pct = 0;
        queue_random(4);
        begin
            int n = 0;
            while (!m_valid && n < 200) begin step(); n++; end
            check("stall_wait", m_valid, 1);
        end
        repeat (10) begin
            step();
            check("stall_valid", m_valid, 1);
        end
        ready_pct = 100;
        wait_drain();

        // Flush arriving while a full word is being read and the FIFO drains.
        queue_random(4);
        exp_q[exp_q.size()-1].last = 1'b1;
        repeat (4) step();
        flush_now = 1'b1;
        step();
        wait_drain();

        // Flush with nothing gathered emits nothing and leaves no request behind.
        flush_now = 1'b1;
        step();
        repeat (6) begin
            step();
            check("flush_empty_valid", m_valid, 0);
        end
        queue_random(4);
        wait_drain();
`ifdef OUTPUT_PACKER_STATS_EN
        check("word_count_pre_rst", word_count, hs_count);
`endif

        // Reset with a read in flight: that byte is lost, the next word starts at lane 0.
        begin
            logic [W-1:0] b0, b1;
            b0 = W'($urandom); b1 = W'($urandom);
            wr_q.push_back(b0); wr_q.push_back(b1);
            repeat (3) step();
            @(posedge clk);
            #1;
            fifo_rd_data = rd_data_next;
            fifo_empty   = (fq.size() == 0);
            fifo_wr_en   = 1'b0;
            m_ready      = 1'b1;
            flush        = 1'b0;
            #1;
            check("pre_rst_rd_en", fifo_rd_en, 1);
            rstn = 1'b0;
            hs_count = 0;
            model_bytes.delete();
            #1;
            check("async_rd_en", fifo_rd_en, 0);
            check("async_valid", m_valid, 0);
            check("async_data", m_data, 0);
            check("async_keep", m_keep, 0);
            check("async_last", m_last, 0);
            @(negedge clk);
            sample();
            repeat (2) step();
            @(posedge clk);
            #1;
            rstn = 1'b1;
            @(negedge clk);
            sample();
            model_push(b1);
            queue_random(3);
            wait_drain();
        end

        // Randomized traffic with random write gaps, backpressure and flushes.
        for (int ph = 0; ph < 40; ph++) begin
            wr_pct    = 30 + int'($urandom_range(70));
            ready_pct = 40 + int'($urandom_range(60));
            queue_random(1 + int'($urandom_range(9)));
            if ($urandom_range(2) == 0) quiesce_flush();
            else repeat (int'($urandom_range(5))) step();
        end
        ready_pct = 100;
        quiesce_flush();
        check("words_left", exp_q.size(), 0);
`ifdef OUTPUT_PACKER_STATS_EN
        check("word_count_end", word_count, hs_count);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
